// File: rtl/i281_prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// i281_prog_loader_pkg
//  Shared definitions for the i281 program loader: frame field widths, code
//  memory depth, loader FSM state encoding and a small state-decode helper.
// -----------------------------------------------------------------------------
package i281_prog_loader_pkg;

   localparam int BYTE_W   = 8;    // width of one stream byte
   localparam int WORD_W   = 16;   // width of one instruction word
   localparam int CM_DEPTH = 64;   // default code memory depth in words

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LEN,
      ST_HI,
      ST_LO,
      ST_WRITE,
      ST_CHK,
      ST_RELEASE,
      ST_RUN,
      ST_ERROR
   } state_e;

   // States in which the loader is waiting for a stream byte.
   function automatic logic takes_bytes(input state_e s);
      return (s == ST_LEN) || (s == ST_HI) || (s == ST_LO) || (s == ST_CHK);
   endfunction

endpackage

// File: rtl/i281_prog_loader_timeout.sv
// -----------------------------------------------------------------------------
// loader_timeout
//  Clear/enable up-counter with a terminal-count flag. Saturates at TERMINAL so
//  the flag stays asserted until the counter is cleared.
// Ports
//  clock   in  system clock
//  reset   in  asynchronous active-high reset
//  clear   in  synchronous clear (wins over enable)
//  enable  in  count one step
//  tc      out counter equals TERMINAL
// -----------------------------------------------------------------------------
module loader_timeout
   import i281_prog_loader_pkg::*;
#(
   parameter int unsigned TERMINAL = 15
)(
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int CNT_W = (TERMINAL > 0) ? $clog2(TERMINAL + 1) : 1;
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERMINAL);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != TC_VAL)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/i281_prog_loader.sv
// -----------------------------------------------------------------------------
// i281_prog_loader
//  Byte-stream program loader in front of the i281 CPU. Receives a frame
//  {N, N x {hi, lo}, XOR checksum} over a valid/ready byte interface, writes
//  each word to code memory at addresses 0..N-1, then holds the CPU in reset
//  for RST_HOLD cycles before letting it run.
// Ports
//  clock, reset        clock and asynchronous active-high reset
//  start               pulse: begin or restart a load from any state
//  go                  pulse: run CPU without loading (IDLE/ERROR only)
//  byte_valid/data     upstream byte stream
//  byte_ready          loader accepts a byte this cycle
//  cm_we/addr/wdata    code memory write port, one strobe per word
//  cpu_reset, cpu_run  CPU control
//  busy, done, error   status: loading, running, failed
// -----------------------------------------------------------------------------
module i281_prog_loader
   import i281_prog_loader_pkg::*;
#(
   parameter int ADDR_W      = $clog2(CM_DEPTH),
   parameter int TIMEOUT_CYC = 1000000,
   parameter int RST_HOLD    = 4
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              go,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic              byte_ready,
   output logic              cm_we,
   output logic [ADDR_W-1:0] cm_addr,
   output logic [WORD_W-1:0] cm_wdata,
   output logic              cpu_reset,
   output logic              cpu_run,
   output logic              busy,
   output logic              done,
   output logic              error
);

   // One extra bit so a full 2**ADDR_W word count and the final index fit.
   localparam int LEN_W     = ADDR_W + 1;
   localparam int MAX_WORDS = 2 ** ADDR_W;

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   index_q, index_d;
   logic [LEN_W-1:0]   index_inc;
   logic [BYTE_W-1:0]  hi_q, hi_d;
   logic [BYTE_W-1:0]  lo_q, lo_d;
   logic [BYTE_W-1:0]  chk_q, chk_d;

   logic accept;
   logic len_bad;
   logic idle_tc;
   logic hold_tc;
   logic in_release;

   assign accept     = byte_valid & byte_ready;
   assign index_inc  = index_q + LEN_W'(1);
   assign len_bad    = (byte_data == '0) || (int'(byte_data) > MAX_WORDS);
   assign in_release = (state_q == ST_RELEASE);

   // Idle-gap watchdog: restarts on every accepted byte, on start, and whenever
   // the loader is not waiting for a byte (so WRITE does not eat into the budget).
   loader_timeout #(
      .TERMINAL (TIMEOUT_CYC - 1)
   ) u_idle_timeout (
      .clock  (clock),
      .reset  (reset),
      .clear  (start | accept | ~byte_ready),
      .enable (byte_ready),
      .tc     (idle_tc)
   );

   // CPU reset hold: counts only while in RELEASE, so RELEASE lasts RST_HOLD cycles.
   loader_timeout #(
      .TERMINAL (RST_HOLD - 1)
   ) u_rst_hold (
      .clock  (clock),
      .reset  (reset),
      .clear  (start | ~in_release),
      .enable (in_release),
      .tc     (hold_tc)
   );

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         index_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         chk_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         index_q <= index_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         chk_q   <= chk_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      index_d = index_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      chk_d   = chk_q;

      if (start) begin
         // start overrides everything, including a simultaneous go.
         state_d = ST_LEN;
         index_d = '0;
         chk_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_ERROR: begin
               if (go) state_d = ST_RUN;
            end
            ST_LEN: begin
               if (accept) begin
                  if (len_bad) begin
                     state_d = ST_ERROR;
                  end else begin
                     len_d   = LEN_W'(byte_data);
                     state_d = ST_HI;
                  end
               end else if (idle_tc) begin
                  state_d = ST_ERROR;
               end
            end
            ST_HI: begin
               if (accept) begin
                  hi_d    = byte_data;
                  chk_d   = chk_q ^ byte_data;
                  state_d = ST_LO;
               end else if (idle_tc) begin
                  state_d = ST_ERROR;
               end
            end
            ST_LO: begin
               if (accept) begin
                  lo_d    = byte_data;
                  chk_d   = chk_q ^ byte_data;
                  state_d = ST_WRITE;
               end else if (idle_tc) begin
                  state_d = ST_ERROR;
               end
            end
            ST_WRITE: begin
               index_d = index_inc;
               state_d = (index_inc < len_q) ? ST_HI : ST_CHK;
            end
            ST_CHK: begin
               if (accept) begin
                  state_d = (byte_data == chk_q) ? ST_RELEASE : ST_ERROR;
               end else if (idle_tc) begin
                  state_d = ST_ERROR;
               end
            end
            ST_RELEASE: begin
               if (hold_tc) state_d = ST_RUN;
            end
            ST_RUN: begin
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   // Decoded from the state register only; an asynchronous reset therefore
   // drops cm_we immediately and no byte input reaches the write port directly.
   always_comb begin
      byte_ready = takes_bytes(state_q);
      cm_we      = (state_q == ST_WRITE);
      cpu_run    = (state_q == ST_RUN);
      cpu_reset  = (state_q != ST_RUN);
      done       = (state_q == ST_RUN);
      error      = (state_q == ST_ERROR);
      busy       = (state_q == ST_LEN)   || (state_q == ST_HI)  ||
                   (state_q == ST_LO)    || (state_q == ST_WRITE) ||
                   (state_q == ST_CHK)   || (state_q == ST_RELEASE);
   end

   assign cm_addr  = index_q[ADDR_W-1:0];
   assign cm_wdata = {hi_q, lo_q};

endmodule
